// File: rtl/ex_muldiv_stage_if.sv
// EX -> MEM stage bundle: instruction fields presented by ID/EX, registered
// results handed to MEM, and the stall back to ID.
interface ex_muldiv_stage_if #(
  parameter int W     = 32,
  parameter int REG_W = 5
);
  logic             valid_EX;
  logic [3:0]       op_EX;
  logic [W-1:0]     A_EX;
  logic [W-1:0]     B_EX;
  logic [REG_W-1:0] Rd_EX;
  logic             d_write_enable_EX;
  logic             d_load_enable_EX;
  logic             stall_EX;
  logic [W-1:0]     ALU_out_MEM;
  logic [REG_W-1:0] Rd_MEM;
  logic             d_write_enable_MEM;
  logic             d_load_enable_MEM;

  // master: the ID side feeding the stage; slave: the execute stage itself
  modport master (
    output valid_EX, op_EX, A_EX, B_EX, Rd_EX, d_write_enable_EX, d_load_enable_EX,
    input  stall_EX, ALU_out_MEM, Rd_MEM, d_write_enable_MEM, d_load_enable_MEM
  );

  modport slave (
    input  valid_EX, op_EX, A_EX, B_EX, Rd_EX, d_write_enable_EX, d_load_enable_EX,
    output stall_EX, ALU_out_MEM, Rd_MEM, d_write_enable_MEM, d_load_enable_MEM
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// DLX execute stage: single-cycle ALU plus an iterative W-step MUL/DIV engine
// that stalls ID while it runs and feeds bubbles into MEM.
module ex_muldiv_stage #(
  parameter int W     = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  ex_muldiv_stage_if.slave bus
);
  localparam int CNT_W = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] step_reg;
  logic [3:0]       op_reg;
  logic [REG_W-1:0] rd_reg;
  logic             neg_reg;
  logic             div0_reg;
  // MUL: work_a = shifting multiplicand, work_b = shifting multiplier, acc = product.
  // DIV: work_a = dividend shifting out / quotient shifting in, work_b = divisor, acc = remainder.
  logic [W-1:0]     work_a_reg;
  logic [W-1:0]     work_b_reg;
  logic [W-1:0]     acc_reg;

  logic [W-1:0]     alu_out_reg;
  logic [REG_W-1:0] rd_mem_reg;
  logic             we_mem_reg;
  logic             le_mem_reg;

  logic [CNT_W-1:0] shamt;
  logic [W-1:0]     alu_result;
  logic             is_long;
  logic             start;
  logic             stall;
  logic             signed_div;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic [W:0]       rem_shift;
  logic [W:0]       rem_diff;
  logic [W-1:0]     long_result;

  assign shamt = bus.B_EX[CNT_W-1:0];

  always_comb begin
    alu_result = '0;
    case (bus.op_EX)
      OP_ADD:  alu_result = bus.A_EX + bus.B_EX;
      OP_SUB:  alu_result = bus.A_EX - bus.B_EX;
      OP_AND:  alu_result = bus.A_EX & bus.B_EX;
      OP_OR:   alu_result = bus.A_EX | bus.B_EX;
      OP_XOR:  alu_result = bus.A_EX ^ bus.B_EX;
      OP_SLL:  alu_result = bus.A_EX << shamt;
      OP_SRL:  alu_result = bus.A_EX >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(bus.A_EX) >>> shamt);
      OP_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(bus.A_EX) < $signed(bus.B_EX))};
      OP_SLTU: alu_result = {{(W-1){1'b0}}, (bus.A_EX < bus.B_EX)};
      default: alu_result = '0;
    endcase
  end

  assign is_long = bus.valid_EX &&
                   (bus.op_EX == OP_MUL || bus.op_EX == OP_DIV || bus.op_EX == OP_DIVU);
  assign start   = (state_reg == ST_IDLE) && is_long;
  assign stall   = start || (state_reg == ST_BUSY);
  assign bus.stall_EX = stall;

  // Signed divide works on magnitudes; the sign is reapplied when the result is taken.
  assign signed_div = (bus.op_EX == OP_DIV);
  assign a_mag = (signed_div && bus.A_EX[W-1]) ? (~bus.A_EX + 1'b1) : bus.A_EX;
  assign b_mag = (signed_div && bus.B_EX[W-1]) ? (~bus.B_EX + 1'b1) : bus.B_EX;

  assign rem_shift = {acc_reg, work_a_reg[W-1]};
  assign rem_diff  = rem_shift - {1'b0, work_b_reg};

  always_comb begin
    long_result = work_a_reg;
    if (op_reg == OP_MUL) begin
      long_result = acc_reg;
    end else if (div0_reg) begin
      long_result = '1;
    end else if (neg_reg) begin
      long_result = ~work_a_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_BUSY;
      ST_BUSY: if (step_reg == CNT_W'(W-1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      step_reg   <= '0;
      op_reg     <= '0;
      rd_reg     <= '0;
      neg_reg    <= 1'b0;
      div0_reg   <= 1'b0;
      work_a_reg <= '0;
      work_b_reg <= '0;
      acc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg     <= bus.op_EX;
            rd_reg     <= bus.Rd_EX;
            neg_reg    <= signed_div && (bus.A_EX[W-1] ^ bus.B_EX[W-1]);
            div0_reg   <= (bus.B_EX == '0);
            work_a_reg <= a_mag;
            work_b_reg <= b_mag;
            acc_reg    <= '0;
            step_reg   <= '0;
          end
        end
        ST_BUSY: begin
          step_reg <= step_reg + 1'b1;
          if (op_reg == OP_MUL) begin
            if (work_b_reg[0]) acc_reg <= acc_reg + work_a_reg;
            work_a_reg <= work_a_reg << 1;
            work_b_reg <= work_b_reg >> 1;
          end else if (!rem_diff[W]) begin
            acc_reg    <= rem_diff[W-1:0];
            work_a_reg <= {work_a_reg[W-2:0], 1'b1};
          end else begin
            acc_reg    <= rem_shift[W-1:0];
            work_a_reg <= {work_a_reg[W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // MEM pipeline registers: engine result in DONE, bubble while stalled or empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_reg <= '0;
      rd_mem_reg  <= '0;
      we_mem_reg  <= 1'b0;
      le_mem_reg  <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      alu_out_reg <= long_result;
      rd_mem_reg  <= rd_reg;
      we_mem_reg  <= 1'b0;
      le_mem_reg  <= 1'b0;
    end else if (stall || !bus.valid_EX) begin
      alu_out_reg <= '0;
      rd_mem_reg  <= '0;
      we_mem_reg  <= 1'b0;
      le_mem_reg  <= 1'b0;
    end else begin
      alu_out_reg <= alu_result;
      rd_mem_reg  <= bus.Rd_EX;
      we_mem_reg  <= bus.d_write_enable_EX;
      le_mem_reg  <= bus.d_load_enable_EX;
    end
  end

  assign bus.ALU_out_MEM        = alu_out_reg;
  assign bus.Rd_MEM             = rd_mem_reg;
  assign bus.d_write_enable_MEM = we_mem_reg;
  assign bus.d_load_enable_MEM  = le_mem_reg;
endmodule
